// File: rtl/bcd_mult_ctrl_if.sv
// bcd_mult_ctrl_if: request and status bundle between a requester and bcd_mult_ctrl.
// Latency: none; wires only.
// Backpressure: none; the requester watches busy/done. With BCD_MULT_CTRL_BINOUT_EN, bin_out is added.
interface bcd_mult_ctrl_if;
  logic       i_start;
  logic [3:0] i_x;
  logic [3:0] i_y;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [7:0] o_bcd_out;
`ifdef BCD_MULT_CTRL_BINOUT_EN
  logic [7:0] o_bin_out;

  modport master (output i_start, i_x, i_y,
                  input  o_busy, o_done, o_error, o_bcd_out, o_bin_out);
  modport slave  (input  i_start, i_x, i_y,
                  output o_busy, o_done, o_error, o_bcd_out, o_bin_out);
`else
  modport master (output i_start, i_x, i_y,
                  input  o_busy, o_done, o_error, o_bcd_out);
  modport slave  (input  i_start, i_x, i_y,
                  output o_busy, o_done, o_error, o_bcd_out);
`endif
endinterface

// File: rtl/bcd_mult_ctrl.sv
// bcd_mult_ctrl: multiplies two BCD digits (shift-add), converts to packed BCD (double-dabble); BCD_MULT_CTRL_BINOUT_EN adds bin_out.
// Latency: done is sampled high at the 13th edge after a legal request is accepted, at the 1st edge for an illegal one.
// Backpressure: none; start is only sampled in IDLE, requests arriving while busy are dropped, not queued.
module bcd_mult_ctrl #(
  parameter int unsigned DIGIT_MAX = 9
) (
  input  logic           i_clk,
  input  logic           i_reset,
  bcd_mult_ctrl_if.slave bus
);

  localparam logic [3:0] LP_DIGIT_MAX = DIGIT_MAX[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [2:0]  r_cnt;
  logic [7:0]  r_mcand;     // multiplicand, shifted left once per MUL step
  logic [3:0]  r_mplier;    // multiplier, consumed LSB first
  logic [7:0]  r_prod;      // binary product accumulator
  logic [15:0] r_shift;     // {tens, units, binary} double-dabble register
  logic [7:0]  r_bcd_out;
  logic        r_error;
`ifdef BCD_MULT_CTRL_BINOUT_EN
  logic [7:0]  r_bin_out;
`endif

  logic        w_legal;
  logic        w_accept;
  logic        w_last_mul;
  logic        w_last_conv;
  logic        w_busy;
  logic        w_done;
  logic [7:0]  w_prod_nxt;
  logic [15:0] w_dd_adj;
  logic [15:0] w_dd_nxt;

  assign w_legal     = (bus.i_x <= LP_DIGIT_MAX) && (bus.i_y <= LP_DIGIT_MAX);
  assign w_accept    = (r_state == S_IDLE) && bus.i_start;
  assign w_last_mul  = (r_cnt == 3'd3);
  assign w_last_conv = (r_cnt == 3'd7);

  // State register; reset wins over everything, dropping any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status outputs; an illegal operand skips straight to DONE.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.i_start) begin
          w_next_state = w_legal ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (w_last_mul) begin
          w_next_state = S_CONV;
        end
      end
      S_CONV: begin
        if (w_last_conv) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // One shift-add step and one double-dabble step (add 3 to nibbles >= 5, then shift).
  always_comb begin
    w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : 8'h00);
    w_dd_adj   = r_shift;
    if (r_shift[15:12] >= 4'd5) begin
      w_dd_adj[15:12] = r_shift[15:12] + 4'd3;
    end
    if (r_shift[11:8] >= 4'd5) begin
      w_dd_adj[11:8] = r_shift[11:8] + 4'd3;
    end
    w_dd_nxt = w_dd_adj << 1;
  end

  // Datapath: operand capture, multiply, convert, and result/status registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= 3'd0;
      r_mcand   <= 8'h00;
      r_mplier  <= 4'h0;
      r_prod    <= 8'h00;
      r_shift   <= 16'h0000;
      r_bcd_out <= 8'h00;
      r_error   <= 1'b0;
`ifdef BCD_MULT_CTRL_BINOUT_EN
      r_bin_out <= 8'h00;
`endif
    end else begin
      // Counter restarts on every state entry and is held at zero while idle.
      if ((w_next_state != r_state) || (r_state == S_IDLE)) begin
        r_cnt <= 3'd0;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= {4'h0, bus.i_x};
            r_mplier <= bus.i_y;
            r_prod   <= 8'h00;
            if (!w_legal) begin
              r_error <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last_mul) begin
            r_shift <= {8'h00, w_prod_nxt};
          end
        end
        S_CONV: begin
          r_shift <= w_dd_nxt;
          if (w_last_conv) begin
            r_bcd_out <= w_dd_nxt[15:8];
            r_error   <= 1'b0;
`ifdef BCD_MULT_CTRL_BINOUT_EN
            r_bin_out <= r_prod;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy    = w_busy;
  assign bus.o_done    = w_done;
  assign bus.o_error   = r_error;
  assign bus.o_bcd_out = r_bcd_out;
`ifdef BCD_MULT_CTRL_BINOUT_EN
  assign bus.o_bin_out = r_bin_out;
`endif

endmodule
